// File: rtl/riscv_v_rf_dump.sv
// Vector RF dump reader: walks a register range over the syn_addr/syn_data port and streams each register as OUT_W-bit beats.
// Define RISCV_V_RF_DUMP_CSUM_EN to append an XOR checksum beat (adds the dump_csum output).
module riscv_v_rf_dump #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned VLEN     = 128,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned RD_LAT   = 0,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS),
  localparam int unsigned BEATS   = VLEN / OUT_W,
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] syn_addr,
  input  logic [VLEN-1:0]   syn_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [OUT_W-1:0]  dump_data,
  output logic [ADDR_W-1:0] dump_reg,
  output logic [BEAT_W-1:0] dump_beat,
  output logic              dump_last
`ifdef RISCV_V_RF_DUMP_CSUM_EN
  ,
  output logic              dump_csum
`endif
);

  localparam int unsigned CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned WAIT_LAST = (RD_LAT > 0) ? RD_LAT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_CAPTURE, S_SEND, S_CSUM, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [VLEN-1:0]     shadow_q, shadow_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic [OUT_W-1:0]    word;
  logic [ADDR_W-1:0]   cur_next;
`ifdef RISCV_V_RF_DUMP_CSUM_EN
  logic [OUT_W-1:0]    csum_q, csum_d;
`endif

  assign syn_addr = addr_q;
  assign word     = shadow_q[int'(beat_q) * OUT_W +: OUT_W];
  assign cur_next = (cur_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      last_q   <= '0;
      addr_q   <= '0;
      shadow_q <= '0;
      beat_q   <= '0;
      wait_q   <= '0;
`ifdef RISCV_V_RF_DUMP_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      shadow_q <= shadow_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
`ifdef RISCV_V_RF_DUMP_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    addr_d     = addr_q;
    shadow_d   = shadow_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    busy       = 1'b0;
    done       = 1'b0;
    dump_valid = 1'b0;
    dump_data  = '0;
    dump_reg   = '0;
    dump_beat  = '0;
    dump_last  = 1'b0;
`ifdef RISCV_V_RF_DUMP_CSUM_EN
    csum_d     = csum_q;
    dump_csum  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = first_reg;
          last_d  = last_reg;
          addr_d  = first_reg;
          state_d = S_ADDR;
`ifdef RISCV_V_RF_DUMP_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_ADDR: begin
        busy   = 1'b1;
        wait_d = '0;
        state_d = (RD_LAT == 0) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_q == CNT_W'(WAIT_LAST)) state_d = S_CAPTURE;
        else wait_d = wait_q + 1'b1;
      end
      S_CAPTURE: begin
        busy     = 1'b1;
        shadow_d = syn_data;
        beat_d   = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        dump_data  = word;
        dump_reg   = cur_q;
        dump_beat  = beat_q;
`ifndef RISCV_V_RF_DUMP_CSUM_EN
        dump_last  = (beat_q == BEAT_W'(BEATS - 1)) && (cur_q == last_q);
`endif
        if (dump_ready) begin
`ifdef RISCV_V_RF_DUMP_CSUM_EN
          csum_d = csum_q ^ word;
`endif
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            if (cur_q == last_q) begin
`ifdef RISCV_V_RF_DUMP_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end else begin
              // range may wrap past NUM_REGS-1 back to register 0
              cur_d   = cur_next;
              addr_d  = cur_next;
              state_d = S_ADDR;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_CSUM: begin
`ifdef RISCV_V_RF_DUMP_CSUM_EN
        busy       = 1'b1;
        dump_valid = 1'b1;
        dump_data  = csum_q;
        dump_reg   = last_q;
        dump_last  = 1'b1;
        dump_csum  = 1'b1;
        if (dump_ready) state_d = S_DONE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_v_rf_dump.sv
// Directed self-checking bench for riscv_v_rf_dump (default parameters, async RF read model).
module tb_riscv_v_rf_dump;

  logic         clk = 1'b0;
  logic         rst, start, busy, done, dump_valid, dump_ready, dump_last;
  logic [4:0]   first_reg, last_reg, syn_addr, dump_reg;
  logic [127:0] syn_data;
  logic [31:0]  dump_data;
  logic [1:0]   dump_beat;
`ifdef RISCV_V_RF_DUMP_CSUM_EN
  logic         dump_csum;
`endif

  logic [127:0] rf [32];
  assign syn_data = rf[syn_addr];

  always #5 clk = ~clk;

  riscv_v_rf_dump #(.NUM_REGS(32), .VLEN(128), .OUT_W(32), .RD_LAT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .busy(busy), .done(done), .syn_addr(syn_addr), .syn_data(syn_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_reg(dump_reg), .dump_beat(dump_beat), .dump_last(dump_last)
`ifdef RISCV_V_RF_DUMP_CSUM_EN
    , .dump_csum(dump_csum)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] q_data[$];
  logic [4:0]  q_reg[$];
  logic [1:0]  q_beat[$];
  bit          q_last[$];
  bit          q_csum[$];
  int          q_cyc[$];
  int          n_done;
  bit          timed_out;
  int          stall_bad;

  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk);
    first_reg = f; last_reg = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records every handshaked beat until done; optionally stalls at beat index stall_idx
  // and pulses start (range 7..7) at cycle poke_cyc.
  task automatic collect(input int max_cyc, input int stall_idx, input int poke_cyc);
    int stall_left = 0;
    logic [31:0] hd;
    logic [4:0]  hr;
    logic [1:0]  hb;
    q_data.delete(); q_reg.delete(); q_beat.delete(); q_last.delete(); q_csum.delete(); q_cyc.delete();
    n_done = 0; timed_out = 1'b1; stall_bad = 0; dump_ready = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      start = (c == poke_cyc);
      if (c == poke_cyc) begin first_reg = 5'd7; last_reg = 5'd7; end
      if (done) begin n_done++; timed_out = 1'b0; break; end
      if (stall_left > 0) begin
        if (!dump_valid || dump_data !== hd || dump_reg !== hr || dump_beat !== hb) stall_bad++;
        stall_left--;
        if (stall_left > 0) continue;
        dump_ready = 1'b1;
      end else if (dump_valid && q_data.size() == stall_idx) begin
        hd = dump_data; hr = dump_reg; hb = dump_beat;
        dump_ready = 1'b0; stall_left = 5; stall_idx = -1;
        continue;
      end
      if (dump_valid && dump_ready) begin
        q_data.push_back(dump_data); q_reg.push_back(dump_reg); q_beat.push_back(dump_beat);
        q_last.push_back(dump_last); q_cyc.push_back(c);
`ifdef RISCV_V_RF_DUMP_CSUM_EN
        q_csum.push_back(dump_csum);
`else
        q_csum.push_back(1'b0);
`endif
      end
    end
    start = 1'b0; dump_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dump_ready = 1'b1; first_reg = '0; last_reg = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (dump_valid !== 1'b0 || dump_last !== 1'b0) begin failures++; $display("FAIL reset_valid_last valid=%b last=%b expected 0 0", dump_valid, dump_last); end
    checks++; if (syn_addr !== 5'd0) begin failures++; $display("FAIL reset_syn_addr got=%0d expected 0", syn_addr); end
    checks++; if (dump_data !== 32'd0 || dump_reg !== 5'd0 || dump_beat !== 2'd0) begin failures++; $display("FAIL reset_payload data=%h reg=%0d beat=%0d expected 0 0 0", dump_data, dump_reg, dump_beat); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    rf[3] = 128'h44444444_33333333_22222222_11111111;
    do_start(5'd3, 5'd3);
    checks++; if (busy !== 1'b1 || syn_addr !== 5'd3) begin failures++; $display("FAIL single_fetch busy=%b syn_addr=%0d expected 1 3", busy, syn_addr); end
    collect(100, -1, -1);
    checks++; if (timed_out || q_data.size() != 4) begin failures++; $display("FAIL single_count beats=%0d timeout=%b expected 4 0", q_data.size(), timed_out); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_data[i] !== 32'h11111111 * (i + 1) || q_beat[i] !== 2'(i) || q_reg[i] !== 5'd3 || q_last[i] !== (i == 3)) begin
        failures++;
        $display("FAIL single_beat%0d data=%h beat=%0d reg=%0d last=%b expected %h %0d 3 %b", i, q_data[i], q_beat[i], q_reg[i], q_last[i], 32'h11111111 * (i + 1), i, (i == 3));
      end
    end
    checks++; if (q_cyc[3] - q_cyc[0] != 3) begin failures++; $display("FAIL single_back_to_back span=%0d expected 3", q_cyc[3] - q_cyc[0]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_in_done got=%b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b expected 0", done); end
  endtask

  task automatic test_wrap();
    int regs[4] = '{30, 31, 0, 1};
    for (int i = 0; i < 32; i++) rf[i] = {4{32'(i)}};
    do_start(5'd30, 5'd1);
    collect(300, -1, -1);
    checks++; if (timed_out || n_done != 1 || q_data.size() != 16) begin failures++; $display("FAIL wrap_count beats=%0d done=%0d expected 16 1", q_data.size(), n_done); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (q_reg[i] !== 5'(regs[i / 4]) || q_data[i] !== 32'(regs[i / 4]) || q_beat[i] !== 2'(i % 4) || q_last[i] !== (i == 15)) begin
        failures++;
        $display("FAIL wrap_beat%0d reg=%0d data=%h beat=%0d last=%b expected reg %0d beat %0d", i, q_reg[i], q_data[i], q_beat[i], q_last[i], regs[i / 4], i % 4);
      end
    end
    checks++; if (q_cyc[4] - q_cyc[3] != 3) begin failures++; $display("FAIL wrap_reg_gap gap=%0d expected 3", q_cyc[4] - q_cyc[3]); end
  endtask

  task automatic test_backpressure();
    rf[5] = 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1;
    do_start(5'd5, 5'd5);
    collect(200, 2, -1);
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_hold unstable_cycles=%0d expected 0", stall_bad); end
    checks++; if (timed_out || q_data.size() != 4) begin failures++; $display("FAIL bp_count beats=%0d expected 4", q_data.size()); end
    checks++;
    if (q_data[0] !== 32'hA1A1A1A1 || q_data[1] !== 32'hB2B2B2B2 || q_data[2] !== 32'hC3C3C3C3 || q_data[3] !== 32'hD4D4D4D4) begin
      failures++; $display("FAIL bp_order got=%h %h %h %h expected a1a1a1a1 b2b2b2b2 c3c3c3c3 d4d4d4d4", q_data[0], q_data[1], q_data[2], q_data[3]);
    end
  endtask

  task automatic test_start_busy();
    rf[10] = {4{32'hAAAA0010}};
    rf[11] = {4{32'hBBBB0011}};
    rf[7]  = {4{32'hDEAD0007}};
    do_start(5'd10, 5'd11);
    collect(200, -1, 3);
    checks++; if (timed_out || n_done != 1 || q_data.size() != 8) begin failures++; $display("FAIL busy_count beats=%0d done=%0d expected 8 1", q_data.size(), n_done); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q_reg[i] !== ((i < 4) ? 5'd10 : 5'd11) || q_data[i] !== ((i < 4) ? 32'hAAAA0010 : 32'hBBBB0011)) begin
        failures++; $display("FAIL busy_beat%0d reg=%0d data=%h expected reg %0d", i, q_reg[i], q_data[i], (i < 4) ? 10 : 11);
      end
    end
    start = 1'b1;  // start presented during the done cycle
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0 || dump_valid !== 1'b0) begin failures++; $display("FAIL start_in_done busy=%b valid=%b expected 0 0", busy, dump_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int dones = 0;
    for (int i = 0; i < 5; i++) rf[i] = {32'(8'hD0 + i), 32'(8'hC0 + i), 32'(8'hB0 + i), 32'(8'hA0 + i)};
    do_start(5'd0, 5'd4);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (dump_valid && dump_reg == 5'd2 && dump_beat == 2'd1) begin rst = 1'b1; found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL rstmid_reach reached=%b expected 1", found); end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || dump_valid !== 1'b0 || syn_addr !== 5'd0 || done !== 1'b0 || dump_data !== 32'd0) begin
      failures++; $display("FAIL rstmid_outputs busy=%b valid=%b addr=%0d done=%b data=%h expected all 0", busy, dump_valid, syn_addr, done, dump_data);
    end
    repeat (10) begin @(negedge clk); if (done || dump_valid) dones++; end
    checks++; if (dones != 0) begin failures++; $display("FAIL rstmid_quiet active_cycles=%0d expected 0", dones); end
    do_start(5'd0, 5'd0);
    collect(100, -1, -1);
    checks++;
    if (timed_out || q_data.size() != 4 || q_data[0] !== 32'hA0 || q_data[3] !== 32'hD0 || q_last[3] !== 1'b1) begin
      failures++; $display("FAIL rstmid_restart beats=%0d first=%h last=%h expected 4 000000a0 000000d0", q_data.size(), q_data[0], q_data[3]);
    end
  endtask

`ifdef RISCV_V_RF_DUMP_CSUM_EN
  task automatic test_csum();
    rf[0] = {4{32'h1}};
    rf[1] = {4{32'h3}};
    do_start(5'd0, 5'd1);
    collect(200, -1, -1);
    checks++; if (timed_out || q_data.size() != 9) begin failures++; $display("FAIL csum_count beats=%0d expected 9", q_data.size()); end
    checks++;
    if (q_data[8] !== 32'h0 || q_csum[8] !== 1'b1 || q_last[8] !== 1'b1 || q_reg[8] !== 5'd1 || q_beat[8] !== 2'd0) begin
      failures++; $display("FAIL csum_beat data=%h csum=%b last=%b reg=%0d beat=%0d expected 0 1 1 1 0", q_data[8], q_csum[8], q_last[8], q_reg[8], q_beat[8]);
    end
    checks++; if (q_last[7] !== 1'b0 || q_csum[7] !== 1'b0) begin failures++; $display("FAIL csum_data_last last=%b csum=%b expected 0 0", q_last[7], q_csum[7]); end
    rf[1] = {32'h5, 32'h3, 32'h3, 32'h3};
    do_start(5'd0, 5'd1);
    collect(200, -1, -1);
    checks++; if (q_data[8] !== 32'h6) begin failures++; $display("FAIL csum_value got=%h expected 00000006", q_data[8]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
`ifdef RISCV_V_RF_DUMP_CSUM_EN
    test_csum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
